// File: rtl/spi_memory_slave.sv
// SPI mode-0 memory-style slave: opcode, optional address, dummy cycles, then a full-duplex byte stream.
// Define SPI_SLAVE_INPUT_SYNC_EN for 2-flop input synchronizers; otherwise a single input register is used.
module spi_memory_slave #(
    parameter int SCK_MIN_HALF = 4
) (
    input  logic       main_clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] opcode,
    output logic       opcode_valid,
    input  logic       addr_flag,
    input  logic [7:0] dummy_cycles,
    output logic [7:0] addr,
    output logic       addr_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_end,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_DUMMY,
        S_DATA
    } state_e;

    // The transmit byte is loaded one cycle after tx_req and must land before the next sck fall.
    if (SCK_MIN_HALF < 2) begin : g_half_check
        $error("SCK_MIN_HALF must be at least 2");
    end

    logic sck_s_q, cs_s_q, mosi_s_q;
    logic sck_p_q, cs_p_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
`ifdef SPI_SLAVE_INPUT_SYNC_EN
    logic sck_m_q, cs_m_q, mosi_m_q;

    always_ff @(posedge main_clock) begin
        if (reset) begin
            sck_m_q  <= 1'b0;
            cs_m_q   <= 1'b1;
            mosi_m_q <= 1'b0;
            sck_s_q  <= 1'b0;
            cs_s_q   <= 1'b1;
            mosi_s_q <= 1'b0;
        end else begin
            sck_m_q  <= sck;
            cs_m_q   <= cs;
            mosi_m_q <= mosi;
            sck_s_q  <= sck_m_q;
            cs_s_q   <= cs_m_q;
            mosi_s_q <= mosi_m_q;
        end
    end
`else
    always_ff @(posedge main_clock) begin
        if (reset) begin
            sck_s_q  <= 1'b0;
            cs_s_q   <= 1'b1;
            mosi_s_q <= 1'b0;
        end else begin
            sck_s_q  <= sck;
            cs_s_q   <= cs;
            mosi_s_q <= mosi;
        end
    end
`endif

    always_ff @(posedge main_clock) begin
        if (reset) begin
            sck_p_q <= 1'b0;
            cs_p_q  <= 1'b1;
        end else begin
            sck_p_q <= sck_s_q;
            cs_p_q  <= cs_s_q;
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise;
    assign sck_rise = sck_s_q & ~sck_p_q;
    assign sck_fall = ~sck_s_q & sck_p_q;
    assign cs_fall  = ~cs_s_q & cs_p_q;
    assign cs_rise  = cs_s_q & ~cs_p_q;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] dummy_cnt_q, dummy_cnt_d;
    logic [7:0] dummy_len_q, dummy_len_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_load_q, tx_load_d;
    logic       miso_q, miso_d;

    logic [7:0] shift_in;
    logic [7:0] dummy_cnt_inc;
    logic       opcode_pulse, addr_pulse, rx_pulse, tx_req_pulse, frame_end_pulse;

    assign shift_in      = {shift_q[6:0], mosi_s_q};
    assign dummy_cnt_inc = dummy_cnt_q + 8'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the block can infer a latch.
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        dummy_cnt_d     = dummy_cnt_q;
        dummy_len_d     = dummy_len_q;
        opcode_d        = opcode_q;
        addr_d          = addr_q;
        rx_data_d       = rx_data_q;
        opcode_pulse    = 1'b0;
        addr_pulse      = 1'b0;
        rx_pulse        = 1'b0;
        tx_req_pulse    = 1'b0;
        frame_end_pulse = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d   = S_OPCODE;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'd0;
                end
            end
            S_OPCODE, S_ADDR, S_DATA: begin
                if (sck_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == S_OPCODE) begin
                            opcode_pulse = 1'b1;
                            opcode_d     = shift_in;
                            dummy_len_d  = dummy_cycles;
                            dummy_cnt_d  = 8'd0;
                            if (addr_flag) begin
                                state_d = S_ADDR;
                            end else if (dummy_cycles != 8'd0) begin
                                state_d = S_DUMMY;
                            end else begin
                                state_d      = S_DATA;
                                tx_req_pulse = 1'b1;
                            end
                        end else if (state_q == S_ADDR) begin
                            addr_pulse  = 1'b1;
                            addr_d      = shift_in;
                            dummy_cnt_d = 8'd0;
                            if (dummy_len_q != 8'd0) begin
                                state_d = S_DUMMY;
                            end else begin
                                state_d      = S_DATA;
                                tx_req_pulse = 1'b1;
                            end
                        end else begin
                            rx_pulse     = 1'b1;
                            rx_data_d    = shift_in;
                            tx_req_pulse = 1'b1;
                        end
                    end
                end
            end
            S_DUMMY: begin
                if (sck_rise) begin
                    dummy_cnt_d = dummy_cnt_inc;
                    if (dummy_cnt_inc == dummy_len_q) begin
                        state_d      = S_DATA;
                        bit_cnt_d    = 3'd0;
                        tx_req_pulse = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte completing on the same edge as cs rising still reports; no further byte will follow.
        if (cs_rise) begin
            state_d         = S_IDLE;
            frame_end_pulse = (state_q != S_IDLE);
            tx_req_pulse    = 1'b0;
        end
    end

    always_comb begin
        tx_load_d  = tx_req_pulse;
        tx_shift_d = tx_shift_q;
        miso_d     = miso_q;
        if (tx_load_q) begin
            tx_shift_d = tx_data;
        end else if ((state_q == S_DATA) && sck_fall) begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end
        if (state_q != S_DATA) begin
            miso_d = 1'b1;
        end
    end

    always_ff @(posedge main_clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            dummy_cnt_q <= 8'd0;
            dummy_len_q <= 8'd0;
            opcode_q    <= 8'd0;
            addr_q      <= 8'd0;
            rx_data_q   <= 8'd0;
            tx_shift_q  <= 8'd0;
            tx_load_q   <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            dummy_cnt_q <= dummy_cnt_d;
            dummy_len_q <= dummy_len_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            rx_data_q   <= rx_data_d;
            tx_shift_q  <= tx_shift_d;
            tx_load_q   <= tx_load_d;
            miso_q      <= miso_d;
        end
    end

    // Byte outputs forward the completing byte so it is visible in the same cycle as its valid pulse.
    assign opcode_valid = opcode_pulse & ~reset;
    assign addr_valid   = addr_pulse & ~reset;
    assign rx_valid     = rx_pulse & ~reset;
    assign tx_req       = tx_req_pulse & ~reset;
    assign frame_end    = frame_end_pulse & ~reset;
    assign opcode       = opcode_valid ? shift_in : opcode_q;
    assign addr         = addr_valid ? shift_in : addr_q;
    assign rx_data      = rx_valid ? shift_in : rx_data_q;
    assign busy         = ~reset & (state_q != S_IDLE);
    assign miso         = reset | (state_q != S_DATA) | miso_q;

endmodule

// File: tb/tb_spi_memory_slave.sv
// Randomized bench for spi_memory_slave: a bit-level SPI master plus a frame-level reference model
// built from the command layout (opcode, optional address, dummy rises, data bytes).
module tb_spi_memory_slave;
    localparam int HALF = 4;

    logic       main_clock = 1'b0;
    logic       reset, sck, cs, mosi, miso;
    logic [7:0] opcode, addr, rx_data, dummy_cycles;
    logic [7:0] tx_data = 8'h00;
    logic       opcode_valid, addr_valid, tx_req, rx_valid, frame_end, busy, addr_flag;

    spi_memory_slave #(.SCK_MIN_HALF(HALF)) dut (
        .main_clock  (main_clock),
        .reset       (reset),
        .sck         (sck),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .opcode      (opcode),
        .opcode_valid(opcode_valid),
        .addr_flag   (addr_flag),
        .dummy_cycles(dummy_cycles),
        .addr        (addr),
        .addr_valid  (addr_valid),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_end   (frame_end),
        .busy        (busy)
    );

    always #5 main_clock = ~main_clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Observed events; written only by the monitor.
    logic [7:0] op_seen[$];
    logic [7:0] addr_seen[$];
    logic [7:0] rx_seen[$];
    int         op_cyc_q[$];
    int         fe_cyc_q[$];
    int         txreq_rise[$];
    int         busy_err = 0;
    int         cyc      = 0;
    logic       fe_last  = 1'b0;

    // Frame stimulus; written only by the driving process.
    logic [7:0] wr_list[$];
    logic [7:0] tx_list[$];
    int         tx_base_idx = 0;
    int         rise_n      = 0;
    int         op_base, addr_base, rx_base, tx_base, fe_base, berr_base;

    always @(posedge main_clock) begin
        #1;
        cyc++;
        if (opcode_valid) begin
            op_seen.push_back(opcode);
            op_cyc_q.push_back(cyc);
        end
        if (addr_valid) addr_seen.push_back(addr);
        if (rx_valid) rx_seen.push_back(rx_data);
        if (tx_req) begin
            int k;
            k = txreq_rise.size() - tx_base_idx;
            tx_data = (k >= 0 && k < tx_list.size()) ? tx_list[k] : 8'hFF;
            txreq_rise.push_back(rise_n);
        end
        if (fe_last && busy) busy_err++;
        fe_last = frame_end;
        if (frame_end) fe_cyc_q.push_back(cyc);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge main_clock);
    endtask

    task automatic rand_lists(input int n);
        wr_list.delete();
        tx_list.delete();
        for (int i = 0; i < n; i++) wr_list.push_back(8'($urandom));
        for (int i = 0; i <= n; i++) tx_list.push_back(8'($urandom));
    endtask

    // mode 0: full frame with model checks; 1: cs rises after stop_bit bits;
    // 2: stop after stop_bit bits with cs still low; 3: cs rises with the last sck rise.
    task automatic run_frame(input logic [7:0] op, input bit aflag, input logic [7:0] ad,
                             input int dummy, input int mode, input int stop_bit);
        bit         bits[$];
        bit         miso_bits[$];
        int         nbytes;
        int         pre, limit, zeros, n;
        logic [7:0] rd;
        nbytes    = wr_list.size();
        op_base   = op_seen.size();
        addr_base = addr_seen.size();
        rx_base   = rx_seen.size();
        tx_base   = txreq_rise.size();
        fe_base   = fe_cyc_q.size();
        berr_base = busy_err;
        tx_base_idx  = tx_base;
        rise_n       = 0;
        addr_flag    = aflag;
        dummy_cycles = dummy[7:0];
        for (int i = 7; i >= 0; i--) bits.push_back(op[i]);
        if (aflag) for (int i = 7; i >= 0; i--) bits.push_back(ad[i]);
        for (int i = 0; i < dummy; i++) bits.push_back(1'($urandom_range(0, 1)));
        foreach (wr_list[k]) for (int i = 7; i >= 0; i--) bits.push_back(wr_list[k][i]);
        pre   = 8 + (aflag ? 8 : 0) + dummy;
        limit = (stop_bit >= 0) ? stop_bit : bits.size();

        cs = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < limit; i++) begin
            mosi = bits[i];
            wait_cyc(HALF);
            miso_bits.push_back(miso);
            if (mode == 3 && i == limit - 1) cs = 1'b1;
            sck = 1'b1;
            rise_n++;
            wait_cyc(HALF);
            sck = 1'b0;
        end
        if (mode == 2) return;
        wait_cyc(HALF);
        cs = 1'b1;
        wait_cyc(8);
        if (mode != 0) return;

        n = op_seen.size() - op_base;
        check("opcode_cnt", n, 1);
        if (n > 0) check("opcode_val", op_seen[op_base], op);
        n = addr_seen.size() - addr_base;
        check("addr_cnt", n, aflag ? 1 : 0);
        if (aflag && n > 0) check("addr_val", addr_seen[addr_base], ad);
        n = rx_seen.size() - rx_base;
        check("rx_cnt", n, nbytes);
        for (int k = 0; k < n && k < nbytes; k++) check("rx_data", rx_seen[rx_base + k], wr_list[k]);
        n = txreq_rise.size() - tx_base;
        check("tx_req_cnt", n, nbytes + 1);
        if (n > 0) check("first_tx_req_rise", txreq_rise[tx_base], pre);
        check("frame_end_cnt", fe_cyc_q.size() - fe_base, 1);
        check("busy_after_frame_end", busy_err - berr_base, 0);
        zeros = 0;
        for (int i = 0; i < pre; i++) if (!miso_bits[i]) zeros++;
        check("miso_high_before_data", zeros, 0);
        for (int k = 0; k < nbytes; k++) begin
            for (int j = 0; j < 8; j++) rd[7-j] = miso_bits[pre + 8*k + j];
            check("master_read_data", rd, tx_list[k]);
        end
    endtask

    initial begin
        reset = 1'b1;
        cs = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        addr_flag = 1'b0;
        dummy_cycles = 8'd0;
        wait_cyc(5);
        check("reset_busy", busy, 0);
        check("reset_miso", miso, 1);
        check("reset_opcode", opcode, 8'h00);
        check("reset_addr", addr, 8'h00);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_pulses", {opcode_valid, addr_valid, rx_valid, tx_req, frame_end}, 5'b0);
        reset = 1'b0;
        wait_cyc(3);
        check("idle_busy", busy, 0);
        check("idle_miso", miso, 1);

        // Read-ID style: opcode only, immediate data.
        rand_lists(1);
        tx_list[0] = 8'h5A;
        run_frame(8'h9F, 1'b0, 8'h00, 0, 0, -1);

        // Read with address; first tx_req lands on the last address rise.
        rand_lists(2);
        run_frame(8'h03, 1'b1, 8'hAB, 0, 0, -1);

        // Write with address and two data bytes.
        rand_lists(2);
        wr_list[0] = 8'hC4;
        wr_list[1] = 8'h3C;
        run_frame(8'h02, 1'b1, 8'h10, 0, 0, -1);

        // Fast read with 8 dummy rises.
        rand_lists(2);
        run_frame(8'h0B, 1'b1, 8'($urandom), 8, 0, -1);

        // Abort after 5 address bits, then a normal frame.
        rand_lists(1);
        run_frame(8'h03, 1'b1, 8'h55, 0, 1, 13);
        check("abort_opcode_cnt", op_seen.size() - op_base, 1);
        check("abort_addr_cnt", addr_seen.size() - addr_base, 0);
        check("abort_frame_end_cnt", fe_cyc_q.size() - fe_base, 1);
        check("abort_busy_after", busy_err - berr_base, 0);
        check("abort_busy_now", busy, 0);
        rand_lists(1);
        run_frame(8'hA5, 1'b1, 8'h5C, 2, 0, -1);

        // cs rises on the same edge as the 8th opcode bit.
        rand_lists(0);
        run_frame(8'h3E, 1'b0, 8'h00, 0, 3, 8);
        check("coinc_opcode_cnt", op_seen.size() - op_base, 1);
        check("coinc_frame_end_cnt", fe_cyc_q.size() - fe_base, 1);
        if (op_seen.size() > op_base && fe_cyc_q.size() > fe_base) begin
            check("coinc_opcode_val", op_seen[op_base], 8'h3E);
            check("coinc_same_cycle", fe_cyc_q[fe_base], op_cyc_q[op_base]);
        end

        // Reset during DATA with a zero being shifted out.
        rand_lists(2);
        tx_list[0] = 8'h00;
        run_frame(8'h03, 1'b0, 8'h00, 0, 2, 13);
        reset = 1'b1;
        @(posedge main_clock);
        #1;
        check("rst_data_miso", miso, 1);
        check("rst_data_busy", busy, 0);
        wait_cyc(2);
        cs = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(4);
        check("rst_data_no_frame_end", fe_cyc_q.size() - fe_base, 0);
        check("rst_data_busy_after", busy, 0);
        rand_lists(1);
        run_frame(8'h9F, 1'b0, 8'h00, 0, 0, -1);

        // Randomized frames, starting with opcode 0x00.
        for (int f = 0; f < 16; f++) begin
            logic [7:0] op;
            op = (f == 0) ? 8'h00 : 8'($urandom);
            rand_lists(int'($urandom_range(1, 3)));
            run_frame(op, 1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 10)), 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
